// File: rtl/rcpu_bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rcpu_bus_pkg : shared types and constants for the 16-bit memory-mapped bus  |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
package rcpu_bus_pkg;

  localparam int BUS_DW = 16;
  localparam int BUS_AW = 32;

  localparam logic [BUS_AW-1:0] LCD_DATA_ADDR  = 32'h0000_F000;
  localparam logic [BUS_AW-1:0] LCD_CTRL_ADDR  = 32'h0000_F001;
  localparam logic [BUS_AW-1:0] INT_EN_ADDR    = 32'h0000_FFFD;
  localparam logic [BUS_AW-1:0] INT_VEC_LO     = 32'h0000_FFFE;
  localparam logic [BUS_AW-1:0] INT_VEC_HI     = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO     = 3'd1,
    LO_CAP = 3'd2,
    HI     = 3'd3,
    HI_CAP = 3'd4,
    RESP   = 3'd5
  } busState_t;

  // Word address of the high half; wraps modulo 2^32.
  function automatic logic [BUS_AW-1:0] nextWordAddr(input logic [BUS_AW-1:0] a);
    return a + BUS_AW'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bus_wait_timer : per-beat wait counter, flags when a beat has waited too long|
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module bus_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_counted
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] r_count;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_count <= '0;
        end else if (clr) begin
          r_count <= '0;
        end else if (run) begin
          r_count <= r_count + CW'(1);
        end
      end

      assign expired = run && (r_count == CW'(TIMEOUT - 1));
    end else begin : g_unbounded
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_bus_master : splits CPU 16/32-bit loads/stores into 16-bit bus beats     |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module mem_bus_master
  import rcpu_bus_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                req_we,
  input  logic                req_wide,
  input  logic [BUS_AW-1:0]   req_addr,
  input  logic [2*BUS_DW-1:0] req_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2*BUS_DW-1:0] rdata,
  output logic [BUS_AW-1:0]   addr,
  output logic [BUS_DW-1:0]   write,
  output logic                we,
  output logic                re,
  input  logic [BUS_DW-1:0]   read,
  input  logic                ready
);

  busState_t             r_state;
  busState_t             w_nextState;
  logic                  r_isStore;
  logic                  r_isWide;
  logic [BUS_AW-1:0]     r_baseAddr;
  logic [BUS_DW-1:0]     r_wdataHi;

  logic                  w_accept;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_err;
  logic                  w_we;
  logic                  w_re;
  logic [BUS_AW-1:0]     w_addr;
  logic [BUS_DW-1:0]     w_write;
  logic [2*BUS_DW-1:0]   w_rdata;
  logic                  w_inBeat;
  logic                  w_expired;

  assign w_inBeat = (r_state == LO) || (r_state == HI);

  // Counter restarts whenever a beat completes or we are outside a beat.
  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_inBeat || ready),
    .run     (w_inBeat && !ready),
    .expired (w_expired)
  );

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_busy      = busy;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_we        = we;
    w_re        = re;
    w_addr      = addr;
    w_write     = write;
    w_rdata     = rdata;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_nextState = LO;
          w_busy      = 1'b1;
          w_addr      = req_addr;
          w_we        = req_we;
          w_re        = !req_we;
          w_write     = req_wdata[BUS_DW-1:0];
          w_rdata     = '0;
        end
      end
      LO, HI: begin
        if (ready) begin
          if (r_isStore) begin
            if ((r_state == LO) && r_isWide) begin
              w_nextState = HI;
              w_addr      = nextWordAddr(r_baseAddr);
              w_write     = r_wdataHi;
            end else begin
              w_nextState = RESP;
              w_we        = 1'b0;
              w_done      = 1'b1;
            end
          end else begin
            w_re        = 1'b0;
            w_nextState = (r_state == LO) ? LO_CAP : HI_CAP;
          end
        end else if (w_expired) begin
          w_we        = 1'b0;
          w_re        = 1'b0;
          w_err       = 1'b1;
          w_nextState = RESP;
        end
      end
      LO_CAP: begin
        w_rdata[BUS_DW-1:0] = read;
        if (r_isWide) begin
          w_nextState = HI;
          w_addr      = nextWordAddr(r_baseAddr);
          w_re        = 1'b1;
        end else begin
          w_nextState = RESP;
          w_done      = 1'b1;
        end
      end
      HI_CAP: begin
        w_rdata[2*BUS_DW-1:BUS_DW] = read;
        w_nextState = RESP;
        w_done      = 1'b1;
      end
      RESP: begin
        w_nextState = IDLE;
        w_busy      = 1'b0;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      we         <= 1'b0;
      re         <= 1'b0;
      addr       <= '0;
      write      <= '0;
      rdata      <= '0;
      r_isStore  <= 1'b0;
      r_isWide   <= 1'b0;
      r_baseAddr <= '0;
      r_wdataHi  <= '0;
    end else begin
      r_state <= w_nextState;
      busy    <= w_busy;
      done    <= w_done;
      err     <= w_err;
      we      <= w_we;
      re      <= w_re;
      addr    <= w_addr;
      write   <= w_write;
      rdata   <= w_rdata;
      if (w_accept) begin
        r_isStore  <= req_we;
        r_isWide   <= req_wide;
        r_baseAddr <= req_addr;
        r_wdataHi  <= req_wdata[2*BUS_DW-1:BUS_DW];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_bus_master : scoreboard bench for mem_bus_master with a RAM responder |
// | Revision          : 1.0                                                     |
// +-----------------------------------------------------------------------------+
module tb_mem_bus_master;

  typedef struct {
    logic        isErr;
    logic        chkData;
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, reqWe, reqWide, ready;
  logic [31:0] reqAddr, reqWdata;
  logic        busy, done, err, we, re;
  logic [31:0] rdata, addr;
  logic [15:0] write, read;

  logic        tReq;
  logic        tBusy, tDone, tErr, tWe, tRe;
  logic [31:0] tRdata, tAddr;
  logic [15:0] tWrite;

  int          nChecks = 0;
  int          nFails = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  resp_t       respQ[$];
  beat_t       beatQ[$];
  resp_t       curResp;
  beat_t       curBeat;
  bit   [15:0] mem [0:65535];
  logic        capPending = 1'b0;
  logic [31:0] capAddr = '0;

  mem_bus_master #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(reqWe), .req_wide(reqWide),
    .req_addr(reqAddr), .req_wdata(reqWdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .addr(addr), .write(write), .we(we), .re(re), .read(read), .ready(ready)
  );

  mem_bus_master #(.TIMEOUT(4)) dutT (
    .clk(clk), .rst(rst), .req(tReq), .req_we(1'b0), .req_wide(1'b0),
    .req_addr(32'h0000_1234), .req_wdata(32'h0), .busy(tBusy), .done(tDone), .err(tErr),
    .rdata(tRdata), .addr(tAddr), .write(tWrite), .we(tWe), .re(tRe), .read(16'h0), .ready(1'b0)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // RAM-like responder: stores on we&&ready, returns data the cycle after re&&ready.
  always @(posedge clk) begin
    if (ready && we) mem[addr[15:0]] <= write;
    if (ready && re) read <= mem[addr[15:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      capPending <= 1'b0;
    end else begin
      if (capPending) begin
        check("capture re low", {31'b0, re}, 32'h0);
        check("capture addr held", addr, capAddr);
      end
      capPending <= ready && re;
      capAddr    <= addr;
      if (ready && (we || re)) begin
        check("we/re exclusive", {31'b0, we & re}, 32'h0);
        if (beatQ.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected beat: got addr=0x%08h we=%0b, expected none", addr, we);
        end else begin
          curBeat = beatQ.pop_front();
          check("beat we", {31'b0, we}, {31'b0, curBeat.isWrite});
          check("beat addr", addr, curBeat.addr);
          if (curBeat.isWrite) check("beat write", {16'b0, write}, {16'b0, curBeat.data});
        end
      end
      if (done || err) begin
        if (respQ.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected response: got done=%0b err=%0b, expected none", done, err);
        end else begin
          curResp = respQ.pop_front();
          check("resp err", {31'b0, err}, {31'b0, curResp.isErr});
          check("resp done", {31'b0, done}, {31'b0, !curResp.isErr});
          if (curResp.chkData) check("rdata", rdata, curResp.rdata);
          check("latency", cyc - acceptCyc + 1, curResp.lat);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input logic w, input logic [31:0] a, input logic [15:0] d);
    beat_t b;
    b.isWrite = w; b.addr = a; b.data = d;
    beatQ.push_back(b);
  endtask

  task automatic pushResp(input logic e, input logic chk, input logic [31:0] rd, input int lat);
    resp_t r;
    r.isErr = e; r.chkData = chk; r.rdata = rd; r.lat = lat;
    respQ.push_back(r);
  endtask

  task automatic issue(input logic w, input logic wide, input logic [31:0] a, input logic [31:0] wd);
    int guard = 0;
    while (busy && guard < 50) begin
      tick(1);
      guard++;
    end
    if (busy) begin
      nChecks++; nFails++;
      $display("FAIL issue: got busy=1, expected 0");
    end
    reqWe = w; reqWide = wide; reqAddr = a; reqWdata = wd; req = 1'b1;
    tick(1);
    acceptCyc = cyc;
    req = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((busy || respQ.size() != 0) && guard < 60) begin
      tick(1);
      guard++;
    end
    nChecks++;
    if (busy || respQ.size() != 0 || beatQ.size() != 0) begin
      nFails++;
      $display("FAIL idle: got busy=%0b resp=%0d beats=%0d, expected 0/0/0",
               busy, respQ.size(), beatQ.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = 1'b0; reqWe = 1'b0; reqWide = 1'b0; reqAddr = '0; reqWdata = '0;
    ready = 1'b1; tReq = 1'b0;
    tick(2);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done/err", {30'b0, done, err}, 32'h0);
    check("reset we/re", {30'b0, we, re}, 32'h0);
    check("reset addr", addr, 32'h0);
    check("reset write", {16'b0, write}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    rst = 1'b1;
    tick(1);

    // store16 to the LCD data register
    pushBeat(1'b1, 32'h0000_F000, 16'h0041);
    pushResp(1'b0, 1'b0, 32'h0, 2);
    issue(1'b1, 1'b0, 32'h0000_F000, 32'h0000_0041);
    waitIdle();
    check("LCD data", {16'b0, mem[16'hF000]}, 32'h0000_0041);

    // store32 across the interrupt vector pair
    pushBeat(1'b1, 32'h0000_FFFE, 16'h5678);
    pushBeat(1'b1, 32'h0000_FFFF, 16'h1234);
    pushResp(1'b0, 1'b0, 32'h0, 3);
    issue(1'b1, 1'b1, 32'h0000_FFFE, 32'h1234_5678);
    waitIdle();
    check("intAddr", {mem[16'hFFFF], mem[16'hFFFE]}, 32'h1234_5678);

    // two store16 then load32 of the pair
    pushBeat(1'b1, 32'h0000_C010, 16'hBEEF);
    pushResp(1'b0, 1'b0, 32'h0, 2);
    issue(1'b1, 1'b0, 32'h0000_C010, 32'h0000_BEEF);
    pushBeat(1'b1, 32'h0000_C011, 16'hCAFE);
    pushResp(1'b0, 1'b0, 32'h0, 2);
    issue(1'b1, 1'b0, 32'h0000_C011, 32'h0000_CAFE);
    waitIdle();
    pushBeat(1'b0, 32'h0000_C010, 16'h0);
    pushBeat(1'b0, 32'h0000_C011, 16'h0);
    pushResp(1'b0, 1'b1, 32'hCAFE_BEEF, 5);
    issue(1'b0, 1'b1, 32'h0000_C010, 32'h0);
    waitIdle();

    // load16 with ready high
    pushBeat(1'b0, 32'h0000_F000, 16'h0);
    pushResp(1'b0, 1'b1, 32'h0000_0041, 3);
    issue(1'b0, 1'b0, 32'h0000_F000, 32'h0);
    waitIdle();

    // load16 with ready held low for the first three beat cycles
    pushBeat(1'b0, 32'h0000_C011, 16'h0);
    pushResp(1'b0, 1'b1, 32'h0000_CAFE, 6);
    ready = 1'b0;
    issue(1'b0, 1'b0, 32'h0000_C011, 32'h0);
    tick(3);
    ready = 1'b1;
    waitIdle();

    // address wrap at the top of the space
    pushBeat(1'b1, 32'hFFFF_FFFF, 16'h5555);
    pushBeat(1'b1, 32'h0000_0000, 16'hAAAA);
    pushResp(1'b0, 1'b0, 32'h0, 3);
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555);
    waitIdle();
    pushBeat(1'b0, 32'hFFFF_FFFF, 16'h0);
    pushBeat(1'b0, 32'h0000_0000, 16'h0);
    pushResp(1'b0, 1'b1, 32'hAAAA_5555, 5);
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    waitIdle();

    // TIMEOUT=4 instance with ready stuck low
    tReq = 1'b1;
    tick(1);
    tReq = 1'b0;
    check("timeout addr", tAddr, 32'h0000_1234);
    check("timeout we", {31'b0, tWe}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check("timeout re held", {31'b0, tRe}, 32'h1);
      check("timeout no err yet", {31'b0, tErr}, 32'h0);
      tick(1);
    end
    check("timeout re dropped", {31'b0, tRe}, 32'h0);
    check("timeout err", {31'b0, tErr}, 32'h1);
    check("timeout done", {31'b0, tDone}, 32'h0);
    check("timeout busy", {31'b0, tBusy}, 32'h1);
    check("timeout rdata", tRdata, 32'h0);
    check("timeout write", {16'b0, tWrite}, 32'h0);
    tick(1);
    check("timeout err single", {31'b0, tErr}, 32'h0);
    check("timeout busy clear", {31'b0, tBusy}, 32'h0);

    // reset during the high beat of a store32
    pushBeat(1'b1, 32'h0000_F000, 16'h7766);
    issue(1'b1, 1'b1, 32'h0000_F000, 32'h9988_7766);
    tick(1);
    check("HI addr", addr, 32'h0000_F001);
    check("HI write", {16'b0, write}, 32'h0000_9988);
    rst = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort done/err", {30'b0, done, err}, 32'h0);
    check("abort we/re", {30'b0, we, re}, 32'h0);
    check("abort addr", addr, 32'h0);
    check("abort write", {16'b0, write}, 32'h0);
    tick(2);
    check("abort low written", {16'b0, mem[16'hF000]}, 32'h0000_7766);
    check("abort high untouched", {16'b0, mem[16'hF001]}, 32'h0);
    rst = 1'b1;
    tick(1);
    pushBeat(1'b0, 32'h0000_F000, 16'h0);
    pushResp(1'b0, 1'b1, 32'h0000_7766, 3);
    issue(1'b0, 1'b0, 32'h0000_F000, 32'h0);
    waitIdle();

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
